ngc_counter_sequencer: RTL and testbench

Master-side controller for the ngc counter interface: it accepts a timing command from a host over a valid/ready handshake, then resets, loads and enables the counter. It counts `count_hit` events until the requested number of periods has elapsed, and reports progress and completion back to the host. It sits between host or CSR logic and one counter instance, replacing the testbench master in synthesizable designs.

---
 rtl/ngc_counter_sequencer_if.sv | 22 ++
 rtl/ngc_counter_sequencer.sv | 154 +++++++++++++++
 tb/tb_ngc_counter_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ngc_counter_sequencer_if.sv
// Command handshake between a host (master) and the ngc counter sequencer (slave).
interface ngc_counter_sequencer_if #(
  parameter int COUNT_WIDTH = 8,
  parameter int REP_WIDTH   = 16
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [COUNT_WIDTH-1:0]     cmd_period;
  logic [REP_WIDTH-1:0]       cmd_reps;
  logic                       cmd_dir;
  logic [COUNT_WIDTH/2-1:0]   cmd_step;

  modport master (
    output cmd_valid, cmd_period, cmd_reps, cmd_dir, cmd_step,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_period, cmd_reps, cmd_dir, cmd_step,
    output cmd_ready
  );
endinterface

// File: rtl/ngc_counter_sequencer.sv
// Master-side sequencer for one ngc counter: takes a timing command, clears,
// loads and enables the counter, then counts hits until the requested periods elapse.
module ngc_counter_sequencer #(
  parameter int COUNT_WIDTH = 8,
  parameter int REP_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  ngc_counter_sequencer_if.slave   cmd,
  input  logic                     abort,
  output logic                     busy,
  output logic                     tick,
  output logic                     done,
  output logic                     aborted,
  output logic [REP_WIDTH-1:0]     hit_cnt,
  output logic                     ctr_rst,
  output logic                     ctr_load,
  output logic                     ctr_enb,
  output logic                     ctr_dir,
  output logic                     ctr_one_shot,
  output logic [COUNT_WIDTH-1:0]   ctr_load_value,
  output logic [COUNT_WIDTH-1:0]   ctr_count_from_value,
  output logic [COUNT_WIDTH-1:0]   ctr_count_to_value,
  output logic [COUNT_WIDTH/2-1:0] ctr_step_value,
  input  logic [COUNT_WIDTH-1:0]   ctr_count,
  input  logic                     ctr_count_hit
);

  localparam int STEP_WIDTH = COUNT_WIDTH / 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  logic [2:0]             state_r;
  logic [2:0]             state_nx_s;
  logic [REP_WIDTH-1:0]   reps_r;
  logic [REP_WIDTH-1:0]   hit_cnt_r;
  logic [REP_WIDTH-1:0]   hit_inc_s;
  logic                   tick_r;
  logic                   done_r;
  logic                   aborted_r;
  logic                   ctr_rst_r;
  logic                   ctr_dir_r;
  logic [STEP_WIDTH-1:0]  step_r;
  logic [COUNT_WIDTH-1:0] load_r;
  logic [COUNT_WIDTH-1:0] from_r;
  logic [COUNT_WIDTH-1:0] to_r;

  logic                   accept_s;
  logic                   start_s;
  logic                   abort_take_s;
  logic                   hit_take_s;
  logic                   last_hit_s;
  logic [COUNT_WIDTH-1:0] period_m1_s;
  logic [STEP_WIDTH-1:0]  step_norm_s;

  // The counter value is observed only; keep it referenced so it is not flagged.
  logic unused_ctr_count_s;
  assign unused_ctr_count_s = ^ctr_count;

  assign accept_s     = (state_r == ST_IDLE) && cmd.cmd_valid;
  assign start_s      = accept_s && (cmd.cmd_reps != {REP_WIDTH{1'b0}});
  assign abort_take_s = abort && (state_r != ST_IDLE);
  assign hit_take_s   = ctr_count_hit && (state_r == ST_RUN);
  assign hit_inc_s    = hit_cnt_r + REP_WIDTH'(1);
  assign last_hit_s   = hit_take_s && (hit_inc_s == reps_r);
  assign period_m1_s  = cmd.cmd_period - COUNT_WIDTH'(1);
  assign step_norm_s  = (cmd.cmd_step == {STEP_WIDTH{1'b0}}) ? STEP_WIDTH'(1) : cmd.cmd_step;

  // Next-state decode; abort from any busy state wins over everything else.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          state_nx_s = start_s ? ST_CLEAR : ST_FINISH;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CLEAR:  state_nx_s = abort ? ST_IDLE : ST_LOAD;
      ST_LOAD:   state_nx_s = abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
        end else if (last_hit_s) begin
          state_nx_s = ST_FINISH;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_FINISH: state_nx_s = ST_IDLE;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // State, pulse outputs, hit counter and captured command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      reps_r    <= {REP_WIDTH{1'b0}};
      hit_cnt_r <= {REP_WIDTH{1'b0}};
      tick_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      ctr_rst_r <= 1'b1;
      ctr_dir_r <= 1'b0;
      step_r    <= {STEP_WIDTH{1'b0}};
      load_r    <= {COUNT_WIDTH{1'b0}};
      from_r    <= {COUNT_WIDTH{1'b0}};
      to_r      <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_r   <= state_nx_s;
      tick_r    <= hit_take_s;
      done_r    <= (state_nx_s == ST_FINISH);
      aborted_r <= abort_take_s;
      // The abort cycle also resets the counter so it stops where it is.
      ctr_rst_r <= (state_nx_s == ST_CLEAR) || abort_take_s;
      if (hit_take_s) begin
        hit_cnt_r <= hit_inc_s;
      end else if (start_s) begin
        hit_cnt_r <= {REP_WIDTH{1'b0}};
      end
      if (start_s) begin
        reps_r    <= cmd.cmd_reps;
        ctr_dir_r <= cmd.cmd_dir;
        step_r    <= step_norm_s;
        load_r    <= cmd.cmd_dir ? {COUNT_WIDTH{1'b0}} : period_m1_s;
        from_r    <= cmd.cmd_dir ? {COUNT_WIDTH{1'b0}} : period_m1_s;
        to_r      <= cmd.cmd_dir ? period_m1_s : {COUNT_WIDTH{1'b0}};
      end
    end
  end

  assign cmd.cmd_ready        = (state_r == ST_IDLE);
  assign busy                 = (state_r != ST_IDLE);
  assign ctr_load             = (state_r == ST_LOAD);
  assign ctr_enb              = (state_r == ST_RUN);
  assign ctr_one_shot         = 1'b0;
  assign tick                 = tick_r;
  assign done                 = done_r;
  assign aborted              = aborted_r;
  assign hit_cnt              = hit_cnt_r;
  assign ctr_rst              = ctr_rst_r;
  assign ctr_dir              = ctr_dir_r;
  assign ctr_step_value       = step_r;
  assign ctr_load_value       = load_r;
  assign ctr_count_from_value = from_r;
  assign ctr_count_to_value   = to_r;

endmodule

// File: tb/tb_ngc_counter_sequencer.sv
// Self-checking bench for ngc_counter_sequencer: directed scenarios plus random runs
// checked cycle by cycle against a timeline model of one command.
module tb_ngc_counter_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        abort;
  logic        busy, tick, done, aborted;
  logic [15:0] hit_cnt;
  logic        ctr_rst, ctr_load, ctr_enb, ctr_dir, ctr_one_shot;
  logic [7:0]  ctr_load_value, ctr_count_from_value, ctr_count_to_value;
  logic [3:0]  ctr_step_value;
  logic [7:0]  ctr_count;
  logic        ctr_count_hit;

  int errors = 0;
  int checks = 0;

  ngc_counter_sequencer_if #(.COUNT_WIDTH(8), .REP_WIDTH(16)) cmd_if ();

  ngc_counter_sequencer #(.COUNT_WIDTH(8), .REP_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if), .abort(abort),
    .busy(busy), .tick(tick), .done(done), .aborted(aborted), .hit_cnt(hit_cnt),
    .ctr_rst(ctr_rst), .ctr_load(ctr_load), .ctr_enb(ctr_enb), .ctr_dir(ctr_dir),
    .ctr_one_shot(ctr_one_shot), .ctr_load_value(ctr_load_value),
    .ctr_count_from_value(ctr_count_from_value), .ctr_count_to_value(ctr_count_to_value),
    .ctr_step_value(ctr_step_value), .ctr_count(ctr_count), .ctr_count_hit(ctr_count_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_ready"}, 32'(cmd_if.cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ctr_rst"}, 32'(ctr_rst), 32'd1);
    chk({tag, "_pulses"}, 32'({tick, done, aborted, ctr_load, ctr_enb, ctr_one_shot}), 32'd0);
    chk({tag, "_hit_cnt"}, 32'(hit_cnt), 32'd0);
    chk({tag, "_values"}, 32'({ctr_load_value, ctr_count_from_value, ctr_count_to_value}), 32'd0);
    chk({tag, "_dir_step"}, 32'({ctr_dir, ctr_step_value}), 32'd0);
  endtask

  // One command from offer to return to IDLE. abort_hit>0 aborts once that many hits
  // have been seen (abort_same: together with that hit instead of after it).
  task automatic run_cmd(input logic [7:0] p, input logic [15:0] reps, input logic dir,
                         input logic [3:0] step, input int abort_hit, input bit abort_same,
                         input bit abort_on_accept);
    logic [7:0]  pm1;
    logic [3:0]  exp_step;
    int          hits;
    bit          hit, ab, finished;
    pm1      = p - 8'd1;
    exp_step = (step == 4'd0) ? 4'd1 : step;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_period = p;
    cmd_if.cmd_reps   = reps;
    cmd_if.cmd_dir    = dir;
    cmd_if.cmd_step   = step;
    abort             = abort_on_accept;
    for (int k = 0; k < 40; k++) begin
      if (cmd_if.cmd_ready) break;
      step_cycle();
    end
    chk("ready_wait", 32'(cmd_if.cmd_ready), 32'd1);
    step_cycle();
    cmd_if.cmd_valid = 1'b0;
    abort            = 1'b0;
    if (reps == 16'd0) begin
      chk("zr_done", 32'(done), 32'd1);
      chk("zr_ctrl", 32'({ctr_rst, ctr_load, ctr_enb, cmd_if.cmd_ready}), 32'd0);
      step_cycle();
      chk("zr_ready", 32'(cmd_if.cmd_ready), 32'd1);
      chk("zr_ctrl2", 32'({ctr_rst, ctr_load, ctr_enb, done}), 32'd0);
      return;
    end
    // Cycle 1: CLEAR. Hits here and in LOAD must be ignored.
    chk("clr_ctrl", 32'({ctr_rst, ctr_load, ctr_enb, busy}), 32'b1001);
    chk("clr_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("val_from", 32'(ctr_count_from_value), 32'(dir ? 8'd0 : pm1));
    chk("val_to", 32'(ctr_count_to_value), 32'(dir ? pm1 : 8'd0));
    chk("val_load", 32'(ctr_load_value), 32'(dir ? 8'd0 : pm1));
    chk("val_dir_step", 32'({ctr_dir, ctr_step_value, ctr_one_shot}), 32'({dir, exp_step, 1'b0}));
    ctr_count_hit = 1'($urandom_range(0, 1));
    step_cycle();
    chk("load_ctrl", 32'({ctr_rst, ctr_load, ctr_enb, tick}), 32'b0100);
    ctr_count_hit = 1'($urandom_range(0, 1));
    step_cycle();
    ctr_count_hit = 1'b0;
    chk("run_ctrl", 32'({ctr_rst, ctr_load, ctr_enb, tick}), 32'b0010);
    chk("run_hit_cnt", 32'(hit_cnt), 32'd0);
    hits     = 0;
    finished = 1'b0;
    for (int c = 0; c < 300 && !finished; c++) begin
      hit = ($urandom_range(0, 2) == 0);
      ab  = 1'b0;
      if (abort_hit > 0 && abort_same && hits == abort_hit - 1) begin
        hit = 1'b1;
        ab  = 1'b1;
      end else if (abort_hit > 0 && !abort_same && hits == abort_hit) begin
        hit = 1'b0;
        ab  = 1'b1;
      end
      ctr_count_hit = hit;
      abort         = ab;
      ctr_count     = 8'($urandom);
      step_cycle();
      ctr_count_hit = 1'b0;
      abort         = 1'b0;
      hits          = hits + int'(hit);
      chk("tick", 32'(tick), 32'(hit));
      chk("hit_cnt", 32'(hit_cnt), 32'(hits));
      if (ab) begin
        chk("abt_pulse", 32'({aborted, ctr_rst, done, ctr_enb, busy}), 32'b11000);
        chk("abt_ready", 32'(cmd_if.cmd_ready), 32'd1);
        step_cycle();
        chk("abt_after", 32'({aborted, ctr_rst, done}), 32'd0);
        chk("abt_hold", 32'(hit_cnt), 32'(hits));
        finished = 1'b1;
      end else if (hits == int'(reps)) begin
        chk("fin_done", 32'({done, ctr_enb, busy, aborted}), 32'b1010);
        step_cycle();
        chk("fin_ready", 32'({cmd_if.cmd_ready, busy, done, tick}), 32'b1000);
        chk("fin_hit_cnt", 32'(hit_cnt), 32'(reps));
        finished = 1'b1;
      end else begin
        chk("run_state", 32'({done, ctr_enb, busy, aborted}), 32'b0110);
      end
    end
    chk("run_timeout", 32'(finished), 32'd1);
  endtask

  initial begin
    logic [15:0] r_reps;
    int          r_abort;
    rst = 1'b1;
    abort = 1'b0;
    ctr_count_hit = 1'b0;
    ctr_count = 8'd0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_period = 8'd0;
    cmd_if.cmd_reps = 16'd0;
    cmd_if.cmd_dir = 1'b0;
    cmd_if.cmd_step = 4'd0;
    step_cycle();
    step_cycle();
    chk_idle_reset("rst");
    rst = 1'b0;
    #1;
    chk("rst_release_ctr_rst", 32'(ctr_rst), 32'd1);
    step_cycle();
    chk("rst_fall_ctr_rst", 32'({ctr_rst, cmd_if.cmd_ready}), 32'b01);

    // Up, down, zero reps, abort after 2nd hit, abort with final hit.
    run_cmd(8'd4, 16'd3, 1'b1, 4'd1, 0, 1'b0, 1'b0);
    run_cmd(8'd5, 16'd2, 1'b0, 4'd0, 0, 1'b0, 1'b0);
    run_cmd(8'd9, 16'd0, 1'b1, 4'd2, 0, 1'b0, 1'b0);
    run_cmd(8'd6, 16'd5, 1'b1, 4'd3, 2, 1'b0, 1'b0);
    run_cmd(8'd7, 16'd3, 1'b0, 4'd1, 3, 1'b1, 1'b0);

    // Command held through busy, then period 0 (to = all ones), abort ignored in IDLE.
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_reps  = 16'd0;
    step_cycle();
    cmd_if.cmd_reps  = 16'd2;
    cmd_if.cmd_period = 8'd0;
    chk("stall_not_ready", 32'({cmd_if.cmd_ready, busy, done}), 32'b011);
    step_cycle();
    chk("stall_ready_rises", 32'(cmd_if.cmd_ready), 32'd1);
    run_cmd(8'd0, 16'd2, 1'b1, 4'd5, 0, 1'b0, 1'b1);

    // Random commands.
    for (int i = 0; i < 10; i++) begin
      r_reps  = 16'($urandom_range(0, 6));
      r_abort = 0;
      if (r_reps != 16'd0 && $urandom_range(0, 2) == 0) r_abort = $urandom_range(1, int'(r_reps));
      run_cmd(8'($urandom), r_reps, 1'($urandom), 4'($urandom), r_abort,
              1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) step_cycle();
    end

    // Asynchronous reset during RUN.
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_reps   = 16'd4;
    cmd_if.cmd_period = 8'd10;
    cmd_if.cmd_dir    = 1'b0;
    cmd_if.cmd_step   = 4'd2;
    step_cycle();
    cmd_if.cmd_valid = 1'b0;
    step_cycle();
    step_cycle();
    ctr_count_hit = 1'b1;
    step_cycle();
    ctr_count_hit = 1'b0;
    chk("ar_pre_hit_cnt", 32'({ctr_enb, hit_cnt}), {15'd0, 1'b1, 16'd1});
    #2;
    rst = 1'b1;
    #1;
    chk_idle_reset("async_rst");
    step_cycle();
    rst = 1'b0;
    step_cycle();
    chk("ar_after_release", 32'({ctr_rst, cmd_if.cmd_ready, busy}), 32'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
